// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg
//
// Parametrised register slice placed between two CPU pipeline stages.
// It moves a DATA_W-bit payload with a valid/ready handshake. A one-entry
// skid register absorbs the payload that is already in flight when the
// downstream stage stops accepting. The existing hazard-enable (stall) and
// flush (clear) controls are kept, and a saturating counter records how
// many cycles the stage was stalled.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   in_valid    upstream payload valid
//   in_ready    stage can accept a payload this cycle
//   in_data     upstream payload
//   sig_clr     flush request, discards every held payload at the next edge
//   haz_enable  0 freezes the stage (stall)
//   out_valid   payload presented downstream
//   out_ready   downstream accepts
//   out_data    payload held in the main register
//   stall_cnt   saturating count of stalled cycles, cleared only by reset
// ---------------------------------------------------------------------------
module pipeline_stage_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sig_clr,
  input  logic              haz_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Storage. The pair {main_valid, skid_valid} encodes the occupancy:
  // 00 = EMPTY, 10 = FULL, 11 = SKID. 01 cannot occur.
  logic [DATA_W-1:0] main_data;
  logic              main_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;

  logic              acc;
  logic              fire;
  logic [CNT_W-1:0]  stall_cnt_nxt;

  // Handshake outputs. Clear and stall mask them combinationally so the
  // neighbouring stages see the effect in the same cycle.
  assign in_ready  = rst_n & haz_enable & ~sig_clr & ~skid_valid;
  assign out_valid = main_valid & haz_enable & ~sig_clr;
  assign out_data  = main_data;

  assign acc  = in_valid & in_ready;
  assign fire = out_valid & out_ready;

  // Saturating increment of the stall counter.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt_nxt = stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_nxt = stall_cnt;
    end
  end

  // Payload registers and stall counter. Priority: reset, clear, stall, normal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data  <= CLR_VAL;
      main_valid <= 1'b0;
      skid_data  <= CLR_VAL;
      skid_valid <= 1'b0;
      stall_cnt  <= {CNT_W{1'b0}};
    end else begin
      // A stalled cycle is counted even when a clear wins the same cycle.
      if (!haz_enable) begin
        stall_cnt <= stall_cnt_nxt;
      end

      if (sig_clr) begin
        main_data  <= CLR_VAL;
        main_valid <= 1'b0;
        skid_data  <= CLR_VAL;
        skid_valid <= 1'b0;
      end else if (!haz_enable) begin
        // Stalled: every payload register holds.
        main_valid <= main_valid;
      end else begin
        case ({main_valid, skid_valid})
          2'b00: begin
            if (acc) begin
              main_data  <= in_data;
              main_valid <= 1'b1;
            end
          end
          2'b10: begin
            if (fire && acc) begin
              main_data <= in_data;
            end else if (fire) begin
              // main_data keeps its stale value; only the valid drops.
              main_valid <= 1'b0;
            end else if (acc) begin
              // Downstream stalled while a payload was in flight: park it.
              skid_data  <= in_data;
              skid_valid <= 1'b1;
            end
          end
          2'b11: begin
            if (fire) begin
              main_data  <= skid_data;
              skid_valid <= 1'b0;
            end
          end
          default: begin
            // Skid without main is unreachable; recover to EMPTY.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        sig_clr;
  logic        haz_enable;
  logic        out_ready;
  wire         in_ready;
  wire         out_valid;
  wire  [63:0] out_data;
  wire  [15:0] stall_cnt;

  wire         in_ready4;
  wire         out_valid4;
  wire  [7:0]  out_data4;
  wire  [3:0]  stall_cnt4;

  int total = 0;
  int bad   = 0;

  // Reference model: the stage is a FIFO of capacity two, plus the last
  // value shown on out_data and a saturating stall count.
  logic [63:0] q[$];
  logic [63:0] last_out = 64'h0;
  int unsigned cnt  = 0;
  int unsigned cnt4 = 0;

  logic [63:0] acc_log[$];
  logic [63:0] out_log[$];

  always #5 clk = ~clk;

  pipeline_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sig_clr(sig_clr), .haz_enable(haz_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipeline_stage_reg #(.DATA_W(8), .CLR_VAL(8'h00), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data[7:0]), .sig_clr(sig_clr), .haz_enable(haz_enable),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .stall_cnt(stall_cnt4)
  );

  function automatic logic m_ready();
    return rst_n && haz_enable && !sig_clr && (q.size() < 2);
  endfunction

  function automatic logic m_valid();
    return (q.size() > 0) && haz_enable && !sig_clr;
  endfunction

  // One clock edge: advance the model with the inputs applied before it.
  task automatic tick();
    logic acc, fire;
    acc  = in_valid && m_ready();
    fire = m_valid() && out_ready;
    if (in_valid && in_ready) acc_log.push_back(in_data);
    if (out_valid && out_ready) out_log.push_back(out_data);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      last_out = 64'h0;
      cnt  = 0;
      cnt4 = 0;
    end else begin
      if (!haz_enable) begin
        if (cnt < 65535) cnt++;
        if (cnt4 < 15) cnt4++;
      end
      if (sig_clr) begin
        q.delete();
        last_out = 64'h0;
      end else if (haz_enable) begin
        if (fire) void'(q.pop_front());
        if (acc) q.push_back(in_data);
        if (q.size() > 0) last_out = q[0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sig_clr = 1'b0; haz_enable = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h1111111199999999;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pre_edge_out_valid: got %b expected 0", out_valid); end
    tick();
    total++; if (out_data !== 64'h1111111199999999) begin bad++; $display("FAIL pass_out_data: got %h expected 1111111199999999", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_out_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_stall();
    haz_enable = 1'b0; in_data = 64'h2222222288888888;
    repeat (3) tick();
    total++; if (out_data !== 64'h1111111199999999) begin bad++; $display("FAIL stall_out_data: got %h expected 1111111199999999", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_out_valid: got %b expected 0", out_valid); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt3: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_clear_during_stall();
    haz_enable = 1'b0; sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL clr_out_data: got %h expected 0", out_data); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL clr_stall_cnt: got %0d expected 4", stall_cnt); end
    haz_enable = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_main_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_skid();
    logic [63:0] a, b, c;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    in_valid = 1'b1; in_data = a; out_ready = 1'b0;
    tick();
    in_data = b;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_full: got %b expected 1", in_ready); end
    tick();
    in_data = c;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready_skid: got %b expected 0", in_ready); end
    tick();
    total++; if (out_data !== a) begin bad++; $display("FAIL skid_hold_a: got %h expected %h", out_data, a); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_c_held: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== a) begin bad++; $display("FAIL drain_a: got %b/%h expected 1/%h", out_valid, out_data, a); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== b) begin bad++; $display("FAIL drain_b: got %b/%h expected 1/%h", out_valid, out_data, b); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== c) begin bad++; $display("FAIL drain_c: got %b/%h expected 1/%h", out_valid, out_data, c); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    haz_enable = 1'b0; in_valid = 1'b0;
    repeat (20) tick();
    total++; if (stall_cnt4 !== 4'hF) begin bad++; $display("FAIL sat_cnt4: got %h expected f", stall_cnt4); end
    total++; if (stall_cnt !== 16'(cnt)) begin bad++; $display("FAIL sat_cnt16: got %0d expected %0d", stall_cnt, cnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; haz_enable = 1'b1;
    total++; if (stall_cnt4 !== 4'h0) begin bad++; $display("FAIL sat_reset4: got %h expected 0", stall_cnt4); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL sat_reset16: got %h expected 0", stall_cnt); end
  endtask

  task automatic test_random_stream();
    acc_log.delete();
    out_log.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      haz_enable = ($urandom_range(0, 99) < 85);
      in_data    = {$urandom, $urandom};
      #1;
      total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, m_ready()); end
      total++; if (out_valid !== m_valid()) begin bad++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, m_valid()); end
      total++; if (out_data !== last_out) begin bad++; $display("FAIL rnd_out_data[%0d]: got %h expected %h", i, out_data, last_out); end
      total++; if (stall_cnt !== 16'(cnt)) begin bad++; $display("FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, cnt); end
      total++; if (stall_cnt4 !== 4'(cnt4)) begin bad++; $display("FAIL rnd_stall_cnt4[%0d]: got %0d expected %0d", i, stall_cnt4, cnt4); end
      total++; if (out_data4 !== last_out[7:0] || in_ready4 !== m_ready() || out_valid4 !== m_valid()) begin
        bad++; $display("FAIL rnd_narrow[%0d]: got %h/%b/%b expected %h/%b/%b", i, out_data4, in_ready4, out_valid4, last_out[7:0], m_ready(), m_valid());
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; haz_enable = 1'b1;
    repeat (3) tick();
    total++; if (out_log.size() != acc_log.size()) begin bad++; $display("FAIL rnd_count: got %0d expected %0d", out_log.size(), acc_log.size()); end
    for (int i = 0; i < acc_log.size() && i < out_log.size(); i++) begin
      total++; if (out_log[i] !== acc_log[i]) begin bad++; $display("FAIL rnd_order[%0d]: got %h expected %h", i, out_log[i], acc_log[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_clear_during_stall();
    test_skid();
    test_saturation();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
